// File: rtl/arb_pkg.sv
// arb_pkg: shared state type, index-width derivation and one-hot decode for the weighted arbiter
package arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int MAX_REQ = 256;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < MAX_REQ; i++) if (oh[i]) r = r | i;
    return r;
  endfunction
endpackage

// File: rtl/rr_pick_onehot.sv
// rr_pick_onehot: one-hot round-robin pick, searching upward from the bit after last and wrapping
module rr_pick_onehot #(
  parameter int N_REQ = 8
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] last,
  output logic [N_REQ-1:0] pick
);
  logic [N_REQ-1:0] le, upper;
  // le covers last and every bit below it; a top-bit pointer wraps to all ones
  assign le = {last[N_REQ-2:0], 1'b0} - N_REQ'(1);
  assign upper = req & ~le;
  assign pick = (|upper) ? (upper & (~upper + N_REQ'(1))) : (req & (~req + N_REQ'(1)));
endmodule

// File: rtl/wrr_arbiter.sv
// wrr_arbiter: weighted round-robin arbiter with registered one-hot grant and beat credit; WRR_ARB_LOCK_EN adds a lock input
module wrr_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ = 8,
  parameter int WEIGHT_W = 4,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*WEIGHT_W-1:0] weight,
  input  logic                      beat,
`ifdef WRR_ARB_LOCK_EN
  input  logic                      lock,
`endif
  output logic [N_REQ-1:0]          gnt,
  output logic                      gnt_valid,
  output logic [IDX_W-1:0]          gnt_idx,
  output logic [WEIGHT_W-1:0]       credit
);
  state_t state, state_n;
  logic [N_REQ-1:0] gnt_n, last, last_n, ptr, pick;
  logic [WEIGHT_W-1:0] credit_n, w_pick, w_load;
  logic [IDX_W-1:0] pick_idx;
  logic locked, rel;
`ifdef WRR_ARB_LOCK_EN
  assign locked = lock;
`else
  assign locked = 1'b0;
`endif
  assign gnt_valid = |gnt;
  assign gnt_idx = IDX_W'(onehot_to_idx(MAX_REQ'(gnt)));
  // while granting, the search starts after the grantee so a release hands over without a bubble
  assign ptr = (state == GRANT) ? gnt : last;
  rr_pick_onehot #(.N_REQ(N_REQ)) u_pick (
    .req (req),
    .last(ptr),
    .pick(pick)
  );
  assign pick_idx = IDX_W'(onehot_to_idx(MAX_REQ'(pick)));
  assign w_pick = weight[pick_idx*WEIGHT_W +: WEIGHT_W];
  assign w_load = (w_pick == '0) ? WEIGHT_W'(1) : w_pick;
  assign rel = !(|(req & gnt)) || (beat && credit == WEIGHT_W'(1) && !locked);
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    credit_n = credit;
    last_n = last;
    if (state == IDLE) begin
      if (|req) begin
        state_n = GRANT;
        gnt_n = pick;
        credit_n = w_load;
      end
    end else if (rel) begin
      last_n = gnt;
      state_n = (|pick) ? GRANT : IDLE;
      gnt_n = pick;
      credit_n = (|pick) ? w_load : '0;
    end else if (beat && credit > WEIGHT_W'(1)) begin
      credit_n = credit - WEIGHT_W'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      credit <= '0;
      last <= {1'b1, {(N_REQ-1){1'b0}}};
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      credit <= credit_n;
      last <= last_n;
    end
  end
endmodule
